// File: rtl/ball_pkg.sv
// Shared definitions for the ball motion controller.
//   ball_state_e  : frame-update FSM states
//   SCREEN_*_DEF  : default active screen size
//   VEL_W         : width of the signed per-frame velocity
//   clamp_speed() : |speed| limited to [min_s, max_s], returned as a signed velocity
package ball_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int VEL_W        = 6;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        UPDATE     = 2'd1,
        RESPAWN    = 2'd2
    } ball_state_e;

    // Magnitude is formed in 11 bits so that -512 does not wrap back to itself.
    function automatic logic signed [VEL_W-1:0] clamp_speed(
        input logic signed [9:0] speed,
        input int                min_s,
        input int                max_s
    );
        logic [10:0] mag;
        if (speed[9]) begin
            mag = 11'd0 - {speed[9], speed};
        end else begin
            mag = {1'b0, speed};
        end
        if (int'(mag) < min_s) begin
            return VEL_W'(min_s);
        end else if (int'(mag) > max_s) begin
            return VEL_W'(max_s);
        end else begin
            return VEL_W'(mag);
        end
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One axis of the ball's per-frame step: pos + vel, clamped to [lo, hi].
// Ports:
//   pos, vel         : current position (unsigned) and velocity (signed)
//   lo, hi           : inclusive limits, 11-bit signed
//   new_pos, new_vel : clamped position; velocity negated on a wall contact
//   under, over      : raw sum fell below lo / rose above hi
module ball_axis_step
    import ball_pkg::*;
(
    input  logic        [9:0]       pos,
    input  logic signed [VEL_W-1:0] vel,
    input  logic signed [10:0]      lo,
    input  logic signed [10:0]      hi,
    output logic        [9:0]       new_pos,
    output logic signed [VEL_W-1:0] new_vel,
    output logic                    under,
    output logic                    over
);

    logic signed [10:0] sum_s;

    // Signed step and wall clamp
    always_comb begin
        sum_s   = $signed({1'b0, pos}) + $signed({{(11-VEL_W){vel[VEL_W-1]}}, vel});
        under   = 1'b0;
        over    = 1'b0;
        new_pos = sum_s[9:0];
        new_vel = vel;
        if (sum_s < lo) begin
            under   = 1'b1;
            new_pos = lo[9:0];
            new_vel = -vel;
        end else if (sum_s > hi) begin
            over    = 1'b1;
            new_pos = hi[9:0];
            new_vel = -vel;
        end else begin
            new_pos = sum_s[9:0];
            new_vel = vel;
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position/velocity owner: one update per video frame, wall bounces,
// hit reversal with cooldown, and miss/respawn handling.
// Ports:
//   clk_25MHz, reset (async, active-high)
//   x_pixel, y_pixel            : current scan position
//   collision_detected          : hit flag (rising edge is what counts)
//   estimated_speed             : signed hit speed, sampled at the capture edge
//   is_hit_area                 : combinational, pixel inside the visible ball
//   ball_x, ball_y, ball_visible: registered ball rectangle
//   miss_count                  : saturating miss counter
// Build option: define BALL_SPEEDUP_EN to add 1 to |vx| on every right-wall bounce.
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int SCREEN_W       = SCREEN_W_DEF,
    parameter int SCREEN_H       = SCREEN_H_DEF,
    parameter int BALL_SIZE      = 16,
    parameter int INIT_VX        = -2,
    parameter int INIT_VY        = 1,
    parameter int MIN_SPEED      = 1,
    parameter int MAX_SPEED      = 12,
    parameter int HIT_COOLDOWN   = 8,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic       clk_25MHz,
    input  logic       reset,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic       collision_detected,
    input  logic [9:0] estimated_speed,
    output logic       is_hit_area,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_visible,
    output logic [7:0] miss_count
);

    localparam int CD_W = $clog2(HIT_COOLDOWN + 1);
    localparam int RS_W = $clog2(RESPAWN_FRAMES + 1);

    localparam logic        [9:0]       X_START  = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic        [9:0]       Y_START  = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
    localparam logic signed [VEL_W-1:0] VX_START = VEL_W'(INIT_VX);
    localparam logic signed [VEL_W-1:0] VY_START = VEL_W'(INIT_VY);
    localparam logic signed [VEL_W-1:0] MAX_V    = VEL_W'(MAX_SPEED);
    localparam logic signed [VEL_W-1:0] ONE_V    = VEL_W'(1);
    // Left limit of 1 makes "sum < lo" equal to "nx <= 0", the miss line.
    localparam logic signed [10:0]      X_LO     = 11'sd1;
    localparam logic signed [10:0]      X_HI     = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0]      Y_LO     = 11'sd0;
    localparam logic signed [10:0]      Y_HI     = 11'(SCREEN_H - BALL_SIZE);
    localparam logic        [10:0]      BALL_SZ  = 11'(BALL_SIZE);
    localparam logic        [CD_W-1:0]  CD_LOAD  = CD_W'(HIT_COOLDOWN);
    localparam logic        [RS_W-1:0]  RS_LAST  = RS_W'(RESPAWN_FRAMES - 1);

    ball_state_e             state_r, next_state_s;
    logic        [9:0]       ball_x_r, ball_y_r, x_nxt_s, y_nxt_s;
    logic signed [VEL_W-1:0] vx_r, vy_r, vx_nxt_s, vy_nxt_s;
    logic signed [VEL_W-1:0] hit_speed_r, spd_nxt_s, vx_eff_s;
    logic                    hit_pending_r, pend_nxt_s;
    logic                    ball_visible_r, vis_nxt_s;
    logic                    coll_d_r;
    logic        [CD_W-1:0]  cooldown_r, cd_nxt_s;
    logic        [RS_W-1:0]  respawn_cnt_r, rs_nxt_s;
    logic        [7:0]       miss_count_r, miss_nxt_s;
    logic                    eof_s, capture_s;
    logic        [9:0]       x_new_s, y_new_s;
    logic signed [VEL_W-1:0] x_vel_new_s, y_vel_new_s;
    logic                    x_under_s, x_over_s, y_under_s, y_over_s;

    assign eof_s    = (x_pixel == 10'(SCREEN_W - 1)) && (y_pixel == 10'(SCREEN_H - 1));
    // A pending hit replaces vx for the step it is consumed in.
    assign vx_eff_s = hit_pending_r ? hit_speed_r : vx_r;
    // No capture while a pending hit is being consumed: that hit starts the cooldown.
    assign capture_s = collision_detected && !coll_d_r && (state_r != RESPAWN)
                       && (cooldown_r == {CD_W{1'b0}})
                       && !((state_r == UPDATE) && hit_pending_r);

    ball_axis_step u_step_x (
        .pos(ball_x_r), .vel(vx_eff_s), .lo(X_LO), .hi(X_HI),
        .new_pos(x_new_s), .new_vel(x_vel_new_s), .under(x_under_s), .over(x_over_s)
    );

    ball_axis_step u_step_y (
        .pos(ball_y_r), .vel(vy_r), .lo(Y_LO), .hi(Y_HI),
        .new_pos(y_new_s), .new_vel(y_vel_new_s), .under(y_under_s), .over(y_over_s)
    );

    // Pixel-inside-visible-ball test, zero latency
    always_comb begin
        if (ball_visible_r
            && ({1'b0, x_pixel} >= {1'b0, ball_x_r}) && ({1'b0, x_pixel} < ({1'b0, ball_x_r} + BALL_SZ))
            && ({1'b0, y_pixel} >= {1'b0, ball_y_r}) && ({1'b0, y_pixel} < ({1'b0, ball_y_r} + BALL_SZ))) begin
            is_hit_area = 1'b1;
        end else begin
            is_hit_area = 1'b0;
        end
    end

    // Next-state and next-register values
    always_comb begin
        next_state_s = state_r;
        x_nxt_s      = ball_x_r;
        y_nxt_s      = ball_y_r;
        vx_nxt_s     = vx_r;
        vy_nxt_s     = vy_r;
        vis_nxt_s    = ball_visible_r;
        cd_nxt_s     = cooldown_r;
        rs_nxt_s     = respawn_cnt_r;
        miss_nxt_s   = miss_count_r;
        pend_nxt_s   = hit_pending_r;
        spd_nxt_s    = hit_speed_r;

        if (capture_s) begin
            pend_nxt_s = 1'b1;
            spd_nxt_s  = clamp_speed(estimated_speed, MIN_SPEED, MAX_SPEED);
        end else begin
            spd_nxt_s  = hit_speed_r;
        end

        case (state_r)
            WAIT_FRAME: begin
                if (eof_s) begin
                    next_state_s = UPDATE;
                end else begin
                    next_state_s = WAIT_FRAME;
                end
            end
            UPDATE: begin
                pend_nxt_s = capture_s;
                if (hit_pending_r) begin
                    cd_nxt_s = CD_LOAD;
                end else if (cooldown_r != {CD_W{1'b0}}) begin
                    cd_nxt_s = cooldown_r - {{(CD_W-1){1'b0}}, 1'b1};
                end else begin
                    cd_nxt_s = cooldown_r;
                end
                x_nxt_s = x_new_s;
                y_nxt_s = y_new_s;
                if (y_under_s || y_over_s) begin
                    vy_nxt_s = y_vel_new_s;
                end else begin
                    vy_nxt_s = vy_r;
                end
                if (x_over_s) begin
`ifdef BALL_SPEEDUP_EN
                    if (vx_eff_s >= MAX_V) begin
                        vx_nxt_s = -MAX_V;
                    end else begin
                        vx_nxt_s = -(vx_eff_s + ONE_V);
                    end
`else
                    vx_nxt_s = x_vel_new_s;
`endif
                end else begin
                    vx_nxt_s = x_vel_new_s;
                end
                // A hit makes vx_eff positive, so a hit always beats the left-edge miss.
                if (x_under_s && vx_eff_s[VEL_W-1]) begin
                    miss_nxt_s   = (miss_count_r == 8'hFF) ? 8'hFF : (miss_count_r + 8'd1);
                    vis_nxt_s    = 1'b0;
                    rs_nxt_s     = {RS_W{1'b0}};
                    pend_nxt_s   = 1'b0;
                    next_state_s = RESPAWN;
                end else begin
                    next_state_s = WAIT_FRAME;
                end
            end
            RESPAWN: begin
                if (eof_s) begin
                    if (respawn_cnt_r == RS_LAST) begin
                        x_nxt_s      = X_START;
                        y_nxt_s      = Y_START;
                        vx_nxt_s     = VX_START;
                        vy_nxt_s     = VY_START;
                        vis_nxt_s    = 1'b1;
                        rs_nxt_s     = {RS_W{1'b0}};
                        next_state_s = WAIT_FRAME;
                    end else begin
                        rs_nxt_s     = respawn_cnt_r + {{(RS_W-1){1'b0}}, 1'b1};
                        next_state_s = RESPAWN;
                    end
                end else begin
                    next_state_s = RESPAWN;
                end
            end
            default: begin
                next_state_s = WAIT_FRAME;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state_r <= WAIT_FRAME;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Ball datapath registers
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            ball_x_r       <= X_START;
            ball_y_r       <= Y_START;
            vx_r           <= VX_START;
            vy_r           <= VY_START;
            ball_visible_r <= 1'b1;
            miss_count_r   <= 8'd0;
            hit_pending_r  <= 1'b0;
            hit_speed_r    <= {VEL_W{1'b0}};
            cooldown_r     <= {CD_W{1'b0}};
            respawn_cnt_r  <= {RS_W{1'b0}};
            coll_d_r       <= 1'b0;
        end else begin
            ball_x_r       <= x_nxt_s;
            ball_y_r       <= y_nxt_s;
            vx_r           <= vx_nxt_s;
            vy_r           <= vy_nxt_s;
            ball_visible_r <= vis_nxt_s;
            miss_count_r   <= miss_nxt_s;
            hit_pending_r  <= pend_nxt_s;
            hit_speed_r    <= spd_nxt_s;
            cooldown_r     <= cd_nxt_s;
            respawn_cnt_r  <= rs_nxt_s;
            coll_d_r       <= collision_detected;
        end
    end

    assign ball_x       = ball_x_r;
    assign ball_y       = ball_y_r;
    assign ball_visible = ball_visible_r;
    assign miss_count   = miss_count_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
`timescale 1ns/1ps
module tb_ball_motion_ctrl;

    logic       clk_25MHz = 1'b0;
    logic       reset;
    logic [9:0] x_pixel, y_pixel, estimated_speed;
    logic       collision_detected;
    logic       is_hit_area, ball_visible;
    logic [9:0] ball_x, ball_y;
    logic [7:0] miss_count;

    ball_motion_ctrl dut (
        .clk_25MHz(clk_25MHz), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .collision_detected(collision_detected), .estimated_speed(estimated_speed),
        .is_hit_area(is_hit_area), .ball_x(ball_x), .ball_y(ball_y),
        .ball_visible(ball_visible), .miss_count(miss_count)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int checks = 0;
    int errors = 0;

    // Frame-level reference model of the ball
    int m_x, m_y, m_vx, m_vy, m_vis, m_miss, m_pend, m_spd, m_cd, m_resp;

    typedef struct {
        int px;
        int py;
        int exp_hit;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic idle_pix();
        x_pixel = 10'($urandom_range(0, 638));
        y_pixel = 10'($urandom_range(0, 479));
    endtask

    function automatic int clampspd(input int raw);
        int s;
        int a;
        s = raw;
        if (s >= 512) s = s - 1024;
        a = (s < 0) ? -s : s;
        if (a < 1) a = 1;
        if (a > 12) a = 12;
        return a;
    endfunction

    task automatic model_reset();
        m_x = 312; m_y = 232; m_vx = -2; m_vy = 1; m_vis = 1;
        m_miss = 0; m_pend = 0; m_spd = 0; m_cd = 0; m_resp = 0;
    endtask

    task automatic model_frame_end();
        int vx;
        int nx;
        int ny;
        if (m_resp > 0) begin
            m_resp--;
            if (m_resp == 0) begin
                m_x = 312; m_y = 232; m_vx = -2; m_vy = 1; m_vis = 1;
            end
            return;
        end
        vx = m_vx;
        if (m_pend != 0) begin
            vx = m_spd; m_pend = 0; m_cd = 8;
        end else if (m_cd > 0) begin
            m_cd--;
        end
        nx = m_x + vx;
        ny = m_y + m_vy;
        if (ny < 0) begin
            m_y = 0; m_vy = -m_vy;
        end else if (ny > 464) begin
            m_y = 464; m_vy = -m_vy;
        end else begin
            m_y = ny;
        end
        if (nx > 624) begin
            m_x = 624;
`ifdef BALL_SPEEDUP_EN
            vx = (vx + 1 > 12) ? -12 : -(vx + 1);
`else
            vx = -vx;
`endif
        end else if (nx <= 0 && vx < 0) begin
            m_miss = (m_miss < 255) ? m_miss + 1 : 255;
            m_vis = 0;
            m_resp = 30;
        end else begin
            m_x = nx;
        end
        m_vx = vx;
    endtask

    task automatic probe(input int px, input int py, input string nm);
        int e;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        if (px == 639 && py == 479) px = 638;
        x_pixel = 10'(px);
        y_pixel = 10'(py);
        #1;
        e = (m_vis != 0 && px >= m_x && px < m_x + 16 && py >= m_y && py < m_y + 16) ? 1 : 0;
        chk(nm, int'(is_hit_area), e);
    endtask

    task automatic do_reset();
        @(posedge clk_25MHz);
        #5;
        collision_detected = 1'b0;
        idle_pix();
        reset = 1'b1;
        #1;
        chk("rst_ball_x", int'(ball_x), 312);
        chk("rst_ball_y", int'(ball_y), 232);
        chk("rst_visible", int'(ball_visible), 1);
        chk("rst_miss", int'(miss_count), 0);
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    // One video frame: idle pixels, optional hit pulse, then end-of-frame and the update cycle
    task automatic run_frame(input bit pulse, input int spd, input int hold);
        idle_pix();
        tick();
        probe(m_x + int'($urandom_range(0, 19)) - 2, m_y + int'($urandom_range(0, 19)) - 2, "hit_area");
        tick();
        if (pulse) begin
            estimated_speed    = 10'(spd);
            collision_detected = 1'b1;
            if (m_resp == 0 && m_cd == 0) begin
                m_pend = 1;
                m_spd  = clampspd(spd);
            end
            repeat (hold) tick();
            collision_detected = 1'b0;
            tick();
        end
        x_pixel = 10'd639;
        y_pixel = 10'd479;
        tick();
        idle_pix();
        tick();
        model_frame_end();
        chk("visible", int'(ball_visible), m_vis);
        chk("miss_count", int'(miss_count), m_miss);
        chk("ball_y", int'(ball_y), m_y);
        if (m_vis != 0) chk("ball_x", int'(ball_x), m_x);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        collision_detected = 1'b0;
        estimated_speed = 10'd0;
        x_pixel = 10'd0;
        y_pixel = 10'd0;
        model_reset();
        do_reset();

        // Hit area around the reset position (312,232)
        tbl[0] = '{312, 232, 1};
        tbl[1] = '{327, 247, 1};
        tbl[2] = '{311, 232, 0};
        tbl[3] = '{328, 240, 0};
        tbl[4] = '{320, 231, 0};
        tbl[5] = '{320, 248, 0};
        tbl[6] = '{320, 240, 1};
        tbl[7] = '{0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            x_pixel = 10'(tbl[i].px);
            y_pixel = 10'(tbl[i].py);
            #1;
            chk($sformatf("tbl_hit_%0d", i), int'(is_hit_area), tbl[i].exp_hit);
        end

        // First frame and hit-area edges
        run_frame(1'b0, 0, 1);
        chk("f1_x", int'(ball_x), 310);
        chk("f1_y", int'(ball_y), 233);
        x_pixel = 10'd311; y_pixel = 10'd235; #1;
        chk("f1_hit_in", int'(is_hit_area), 1);
        x_pixel = 10'd309; #1;
        chk("f1_hit_out", int'(is_hit_area), 0);

        // Hit with -6 held 3 cycles, then cooldown behaviour
        run_frame(1'b1, 10'h3FA, 3);
        chk("hit6_x", int'(ball_x), 316);
        run_frame(1'b0, 0, 1);
        run_frame(1'b1, 40, 1);
        chk("cool_ignored_x", int'(ball_x), 328);
        repeat (5) run_frame(1'b0, 0, 1);
        run_frame(1'b1, 40, 1);
        chk("cool_last_x", int'(ball_x), 364);
        run_frame(1'b1, 40, 1);
        chk("hit40_x", int'(ball_x), 376);
        repeat (8) run_frame(1'b0, 0, 1);
        run_frame(1'b1, 0, 2);
        chk("hit0_x", int'(ball_x), 473);

        // Bottom wall bounce
        begin
            int n = 0;
            while (!(m_y == 464 && m_vy < 0) && n < 400) begin
                run_frame(1'b0, 0, 1);
                n++;
            end
        end
        chk("bottom_y", int'(ball_y), 464);
        run_frame(1'b0, 0, 1);
        chk("bottom_next_y", int'(ball_y), 463);

        // Miss and respawn
        do_reset();
        begin
            int n = 0;
            while (m_vis != 0 && n < 200) begin
                run_frame(1'b0, 0, 1);
                n++;
            end
        end
        chk("miss_cnt", int'(miss_count), 1);
        chk("miss_vis", int'(ball_visible), 0);
        x_pixel = 10'd5; y_pixel = 10'(m_y + 4); #1;
        chk("miss_hit_area", int'(is_hit_area), 0);
        repeat (29) run_frame(1'b0, 0, 1);
        chk("resp29_vis", int'(ball_visible), 0);
        run_frame(1'b0, 0, 1);
        chk("resp_vis", int'(ball_visible), 1);
        chk("resp_x", int'(ball_x), 312);
        chk("resp_y", int'(ball_y), 232);
        run_frame(1'b0, 0, 1);
        chk("resp_next_x", int'(ball_x), 310);
        chk("resp_next_y", int'(ball_y), 233);

        // Hit on the same frame as the left-edge crossing
        do_reset();
        begin
            int n = 0;
            while (m_x > 2 && n < 200) begin
                run_frame(1'b0, 0, 1);
                n++;
            end
        end
        run_frame(1'b1, 10'h3FD, 1);
        chk("edgehit_vis", int'(ball_visible), 1);
        chk("edgehit_miss", int'(miss_count), 0);
        chk("edgehit_x", int'(ball_x), 5);

        // Reset during respawn
        do_reset();
        begin
            int n = 0;
            while (m_vis != 0 && n < 200) begin
                run_frame(1'b0, 0, 1);
                n++;
            end
        end
        repeat (5) run_frame(1'b0, 0, 1);
        chk("pre_rst_vis", int'(ball_visible), 0);
        do_reset();
        chk("post_rst_vis", int'(ball_visible), 1);
        run_frame(1'b0, 0, 1);
        chk("post_rst_x", int'(ball_x), 310);

        // Randomized frames against the model
        do_reset();
        for (int f = 0; f < 600; f++) begin
            run_frame(($urandom_range(0, 3) == 0), int'($urandom_range(0, 1023)),
                      int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Owns the game ball's position and velocity. Updates them once per video frame, bounces the ball off the screen walls, and reverses it on a detected hit. It consumes collision_detected / estimated_speed from the collision stage and drives is_hit_area back into that stage. It also supplies the ball rectangle to the VGA overlay mux.

Parameters:
SCREEN_W, 640, active pixels per line
SCREEN_H, 480, active lines per frame
BALL_SIZE, 16, ball square edge in pixels
INIT_VX, -2, signed start x velocity (px/frame; negative = toward player at left edge)
INIT_VY, 1, signed start y velocity
MIN_SPEED, 1, minimum |vx| after a hit
MAX_SPEED, 12, maximum |vx|
HIT_COOLDOWN, 8, frames after a hit during which further hits are ignored
RESPAWN_FRAMES, 30, frames the ball stays hidden after a miss

Ports:
clk_25MHz  input  1  pixel clock
reset  input  1  asynchronous, active-high
x_pixel  input  10  current scan x
y_pixel  input  10  current scan y
collision_detected  input  1  hit flag from collision stage (may be held several cycles)
estimated_speed  input  10  hit speed, two's-complement signed
is_hit_area  output  1  current pixel lies inside the visible ball
ball_x  output  10  ball top-left x
ball_y  output  10  ball top-left y
ball_visible  output  1  ball drawn / hittable
miss_count  output  8  saturating count of missed balls

Behaviour:
- Reset: ball_x=SCREEN_W/2-BALL_SIZE/2 (312), ball_y=SCREEN_H/2-BALL_SIZE/2 (232), vx=INIT_VX, vy=INIT_VY, ball_visible=1, miss_count=0, hit_pending=0, cooldown=0, state=WAIT_FRAME.
- Reset mid-operation of any state returns immediately to these values.
- is_hit_area is combinational, zero latency: ball_visible && ball_x<=x_pixel<ball_x+BALL_SIZE && ball_y<=y_pixel<ball_y+BALL_SIZE.
- Hit capture: a rising edge of collision_detected sets hit_pending, only while state!=RESPAWN and cooldown==0. All other edges are ignored.
- end_of_frame = (x_pixel==SCREEN_W-1 && y_pixel==SCREEN_H-1).
- FSM states:
  - WAIT_FRAME: on end_of_frame -> UPDATE.
  - UPDATE (exactly 1 cycle): compute the new position and write all registers, then -> WAIT_FRAME, or -> RESPAWN on a miss.
  - RESPAWN: ball_visible=0. Counts RESPAWN_FRAMES end_of_frame events, then reloads the reset position and velocity, sets ball_visible=1, and -> WAIT_FRAME.
- UPDATE arithmetic order:
  - (1) If hit_pending: vx = +clamp(|estimated_speed|, MIN_SPEED, MAX_SPEED), sampled at the capture edge. Clear hit_pending; cooldown=HIT_COOLDOWN.
  - (2) Compute nx=ball_x+vx and ny=ball_y+vy in 11-bit signed.
  - (3) ny<0 -> y=0, vy=-vy. ny>SCREEN_H-BALL_SIZE -> y=SCREEN_H-BALL_SIZE, vy=-vy.
  - (4) nx>SCREEN_W-BALL_SIZE -> x=SCREEN_W-BALL_SIZE, vx=-vx.
  - (5) nx<=0 with vx<0 -> miss: miss_count+1 (saturates at 255) -> RESPAWN.
  - (6) cooldown decrements once per UPDATE when nonzero.
- Simultaneous hit and left-edge crossing in the same UPDATE: the hit wins, so vx is positive and no miss occurs.
- Position and velocity hold between updates; outputs change only on the UPDATE cycle.

Optional Feature:
BALL_SPEEDUP_EN:
- Defined: each right-wall bounce increases |vx| by 1, saturating at MAX_SPEED.
- Undefined: a right-wall bounce only negates vx.

Decomposition:
- Package ball_pkg holds:
  - the state enum (WAIT_FRAME, UPDATE, RESPAWN)
  - the SCREEN_W/SCREEN_H defaults
  - the signed velocity width (6 bits)
  - the clamp function
- One sub-module, ball_axis_step, is instantiated for x and y. It takes pos, vel, lo and hi limits, and returns the new pos, new vel, and under/over flags.

Test Plan:
- Reset, run 1 frame -> ball_x 312→310, ball_y 232→233, is_hit_area high at pixel (311,235) after the update, low at (309,235).
- Reset, run frames until ny>464 -> ball_y clamped to 464, vy becomes -1, next frame ball_y=463.
- collision_detected held 3 cycles with estimated_speed=10'h3FA (-6) -> next update vx=+6, ball_x +6. A second pulse 2 frames later is ignored (vx stays 6).
- estimated_speed=40 -> vx=12. estimated_speed=0 -> vx=1.
- Ball reaches x≤0 with vx<0 -> miss_count=1, ball_visible=0 and is_hit_area=0 for 30 frames, then ball back at (312,232), vx=-2, vy=1.
- Hit pulse and left-edge crossing on the same frame -> no miss, vx positive. Separately, assert reset during RESPAWN -> all outputs at reset values and ball_visible=1 on the next cycle.
